// File: rtl/thermo_scan_scheduler.sv
// Round-robin scan controller sharing one digital thermometer across NUM_CH analog inputs.
// Optional macro THERMO_HYST_EN adds ALARM_HYST degC of release hysteresis to the alarm flags.
module thermo_scan_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int SCAN_PERIOD = 1000,
    parameter int TIMEOUT     = 32,
    parameter int ALARM_HYST  = 2
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 START_I,
    input  logic [NUM_CH*10-1:0] ANALOG_CH_I,
    input  logic [6:0]           ALARM_THRESH_I,
    input  logic [CH_W-1:0]      RD_CH_I,
    output logic [9:0]           THERMO_ANALOG_O,
    output logic                 THERMO_EN_O,
    input  logic [6:0]           THERMO_DEGREE_I,
    input  logic                 THERMO_BUSY_I,
    input  logic                 THERMO_VALID_I,
    output logic [6:0]           RD_DEGREE_O,
    output logic [CH_W-1:0]      ACTIVE_CH_O,
    output logic                 SCAN_DONE_O,
    output logic [NUM_CH-1:0]    ALARM_O,
    output logic                 TIMEOUT_ERR_O
);
    localparam int CNT_MAX = (SCAN_PERIOD > TIMEOUT) ? SCAN_PERIOD : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEPTH   = 1 << CH_W;
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_TRIG, S_WAIT_VALID, S_CAPTURE, S_WAIT_IDLE, S_NEXT, S_PERIOD_WAIT
    } state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CH_W-1:0]  r_ch, w_ch_next;
    logic             w_err_set;
    logic [6:0]       r_sample;
    logic [6:0]       r_deg [NUM_CH];
    logic [9:0]       w_an  [DEPTH];
    logic [6:0]       w_rd  [DEPTH];
    logic             w_hit;

    // Power-of-two views so a CH_W-wide index never runs off the end; spare slots read as 0.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
        if (gi < NUM_CH) begin : g_live
            assign w_an[gi] = ANALOG_CH_I[gi*10 +: 10];
            assign w_rd[gi] = r_deg[gi];
        end else begin : g_spare
            assign w_an[gi] = 10'd0;
            assign w_rd[gi] = 7'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ch_next    = r_ch;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (START_I) begin
                    w_ch_next    = '0;
                    w_state_next = S_SETUP;
                end
            end
            // Hold off the trigger while the converter is still finishing an aborted conversion.
            S_SETUP: begin
                if (!THERMO_BUSY_I) begin
                    w_cnt_next   = '0;
                    w_state_next = S_TRIG;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_NEXT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_TRIG: begin
                w_cnt_next   = '0;
                w_state_next = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (THERMO_VALID_I) begin
                    w_state_next = S_CAPTURE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_NEXT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                w_cnt_next   = '0;
                w_state_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!THERMO_BUSY_I) begin
                    w_state_next = S_NEXT;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_NEXT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                w_cnt_next = '0;
                if (r_ch == LAST_CH) begin
                    w_ch_next    = '0;
                    w_state_next = S_PERIOD_WAIT;
                end else begin
                    w_ch_next    = r_ch + 1'b1;
                    w_state_next = S_SETUP;
                end
            end
            S_PERIOD_WAIT: begin
                if (r_cnt == PERIOD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = START_I ? S_SETUP : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ch    <= w_ch_next;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            THERMO_ANALOG_O <= '0;
            THERMO_EN_O     <= 1'b0;
            ACTIVE_CH_O     <= '0;
            SCAN_DONE_O     <= 1'b0;
            TIMEOUT_ERR_O   <= 1'b0;
            RD_DEGREE_O     <= '0;
            r_sample        <= '0;
        end else begin
            THERMO_EN_O <= (w_state_next == S_TRIG);
            SCAN_DONE_O <= (r_state == S_NEXT) && (r_ch == LAST_CH);
            RD_DEGREE_O <= w_rd[RD_CH_I];
            if (r_state == S_SETUP) begin
                THERMO_ANALOG_O <= w_an[r_ch];
                ACTIVE_CH_O     <= r_ch;
            end
            if (r_state == S_WAIT_VALID && THERMO_VALID_I) begin
                r_sample <= THERMO_DEGREE_I;
            end
            if (w_err_set) begin
                TIMEOUT_ERR_O <= 1'b1;
            end
        end
    end

    assign w_hit = (r_sample >= ALARM_THRESH_I);

`ifdef THERMO_HYST_EN
    localparam logic [6:0] HYST = 7'(ALARM_HYST);
    logic [6:0] w_thr_lo;
    logic       w_clr;
    assign w_thr_lo = (ALARM_THRESH_I > HYST) ? (ALARM_THRESH_I - HYST) : 7'd0;
    assign w_clr    = (r_sample < w_thr_lo);
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        always_ff @(posedge CLK_I) begin
            if (RST_I) begin
                r_deg[gi]   <= '0;
                ALARM_O[gi] <= 1'b0;
            end else if (r_state == S_CAPTURE && r_ch == CH_W'(gi)) begin
                r_deg[gi] <= r_sample;
`ifdef THERMO_HYST_EN
                if (w_hit) begin
                    ALARM_O[gi] <= 1'b1;
                end else if (w_clr) begin
                    ALARM_O[gi] <= 1'b0;
                end
`else
                ALARM_O[gi] <= w_hit;
`endif
            end
        end
    end
endmodule

// File: tb/tb_thermo_scan_scheduler.sv
// Bench for thermo_scan_scheduler: behavioural thermometer stub plus a per-scan reference model.
module tb_thermo_scan_scheduler;
    localparam int NUM_CH = 4, CH_W = 3, SCAN_PERIOD = 20, TIMEOUT = 32, ALARM_HYST = 2;

    logic                 CLK_I = 1'b0;
    logic                 RST_I = 1'b1;
    logic                 START_I = 1'b0;
    logic [NUM_CH*10-1:0] ANALOG_CH_I = '0;
    logic [6:0]           ALARM_THRESH_I = '0;
    logic [CH_W-1:0]      RD_CH_I = '0;
    logic [9:0]           THERMO_ANALOG_O;
    logic                 THERMO_EN_O;
    logic [6:0]           THERMO_DEGREE_I = '0;
    logic                 THERMO_BUSY_I = 1'b0;
    logic                 THERMO_VALID_I = 1'b0;
    logic [6:0]           RD_DEGREE_O;
    logic [CH_W-1:0]      ACTIVE_CH_O;
    logic                 SCAN_DONE_O;
    logic [NUM_CH-1:0]    ALARM_O;
    logic                 TIMEOUT_ERR_O;

    thermo_scan_scheduler #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .SCAN_PERIOD(SCAN_PERIOD),
        .TIMEOUT(TIMEOUT), .ALARM_HYST(ALARM_HYST)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .ANALOG_CH_I(ANALOG_CH_I),
        .ALARM_THRESH_I(ALARM_THRESH_I), .RD_CH_I(RD_CH_I), .THERMO_ANALOG_O(THERMO_ANALOG_O),
        .THERMO_EN_O(THERMO_EN_O), .THERMO_DEGREE_I(THERMO_DEGREE_I), .THERMO_BUSY_I(THERMO_BUSY_I),
        .THERMO_VALID_I(THERMO_VALID_I), .RD_DEGREE_O(RD_DEGREE_O), .ACTIVE_CH_O(ACTIVE_CH_O),
        .SCAN_DONE_O(SCAN_DONE_O), .ALARM_O(ALARM_O), .TIMEOUT_ERR_O(TIMEOUT_ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0, errors = 0;
    int en_cnt = 0, done_cnt = 0, en_busy = 0;
    int en_ch[8] = '{default: 0};
    int drop_ch = -1;
    logic [9:0]        ana[NUM_CH];
    int                exp_deg[NUM_CH] = '{default: 0};
    logic [NUM_CH-1:0] exp_alarm = '0;

    function automatic int conv(input logic [9:0] a);
        return (int'(a) * 100) / 1023;
    endfunction

    function automatic logic alarm_rule(input logic prev, input int d, input int thr);
`ifdef THERMO_HYST_EN
        int lo;
        lo = (thr > ALARM_HYST) ? thr - ALARM_HYST : 0;
        if (d >= thr) return 1'b1;
        if (d < lo) return 1'b0;
        return prev;
`else
        return (d >= thr);
`endif
    endfunction

    // Thermometer stub: busy for a random latency after EN, one VALID pulse unless told to drop it.
    int         s_cnt = 0;
    logic       s_drop = 1'b0;
    logic [6:0] s_deg = '0;
    always @(posedge CLK_I) begin
        if (RST_I) begin
            THERMO_BUSY_I  <= 1'b0;
            THERMO_VALID_I <= 1'b0;
            s_cnt          <= 0;
        end else begin
            THERMO_VALID_I <= 1'b0;
            if (!THERMO_BUSY_I && THERMO_EN_O) begin
                THERMO_BUSY_I <= 1'b1;
                s_cnt         <= int'($urandom_range(6, 2));
                s_deg         <= 7'(conv(THERMO_ANALOG_O));
                s_drop        <= (int'(ACTIVE_CH_O) == drop_ch);
            end else if (THERMO_BUSY_I) begin
                if (s_cnt == 0) begin
                    THERMO_BUSY_I <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 1;
                    if (s_cnt == 1 && !s_drop) begin
                        THERMO_VALID_I  <= 1'b1;
                        THERMO_DEGREE_I <= s_deg;
                    end
                end
            end
        end
    end

    always @(posedge CLK_I) begin
        if (!RST_I) begin
            if (THERMO_EN_O) begin
                en_cnt++;
                en_ch[ACTIVE_CH_O]++;
                if (THERMO_BUSY_I) en_busy++;
            end
            if (SCAN_DONE_O) done_cnt++;
        end
    end

    task automatic apply_analog();
        for (int c = 0; c < NUM_CH; c++) ANALOG_CH_I[c*10 +: 10] = ana[c];
    endtask

    task automatic model_scan(input int skip);
        for (int c = 0; c < NUM_CH; c++) begin
            if (c != skip) begin
                exp_deg[c]   = conv(ana[c]);
                exp_alarm[c] = alarm_rule(exp_alarm[c], exp_deg[c], int'(ALARM_THRESH_I));
            end
        end
    endtask

    task automatic model_clear();
        exp_deg   = '{default: 0};
        exp_alarm = '0;
    endtask

    // One complete scan: START pulses high until the first trigger, then the scan must finish on its own.
    task automatic run_scan(input string name, input int skip);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 0;
        apply_analog();
        drop_ch = skip;
        START_I = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge CLK_I);
            if (THERMO_EN_O) START_I = 1'b0;
            if (done_cnt != d0) ok = 1;
        end
        START_I = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s scan_done: got no SCAN_DONE_O pulse, required one within 2000 cycles", name);
        end
        model_scan(skip);
        repeat (SCAN_PERIOD + 5) @(negedge CLK_I);
        drop_ch = -1;
    endtask

    task automatic read_all(output logic [6:0] rb[8]);
        for (int k = 0; k < 8; k++) begin
            RD_CH_I = 3'(k);
            @(negedge CLK_I);
            rb[k] = RD_DEGREE_O;
        end
    endtask

    task automatic wait_en_ch(input int ch, output bit ok);
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge CLK_I);
            if (THERMO_EN_O && int'(ACTIVE_CH_O) == ch) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_en_ch%0d: got no EN pulse, required one within 500 cycles", ch);
        end
    endtask

    task automatic test_reset();
        logic [6:0] rb[8];
        bit ok;
        RST_I = 1'b1;
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b0;
        @(negedge CLK_I);
        checks++;
        if ({THERMO_EN_O, SCAN_DONE_O, TIMEOUT_ERR_O, ALARM_O, RD_DEGREE_O, THERMO_ANALOG_O, ACTIVE_CH_O} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b done=%b err=%b alarm=%b rd=%0d an=%0d ch=%0d, required all 0",
                     THERMO_EN_O, SCAN_DONE_O, TIMEOUT_ERR_O, ALARM_O, RD_DEGREE_O, THERMO_ANALOG_O, ACTIVE_CH_O);
        end
        for (int c = 0; c < NUM_CH; c++) ana[c] = 10'($urandom_range(1023, 100));
        ALARM_THRESH_I = 7'd0;
        run_scan("reset_prep", -1);
        checks++;
        if (ALARM_O !== exp_alarm) begin
            errors++;
            $display("FAIL reset_prep_alarm: got %b required %b", ALARM_O, exp_alarm);
        end
        START_I = 1'b1;
        wait_en_ch(0, ok);
        @(negedge CLK_I);
        START_I = 1'b0;
        RST_I   = 1'b1;
        RD_CH_I = 3'd2;
        @(negedge CLK_I);
        checks++;
        if ({THERMO_EN_O, ALARM_O, RD_DEGREE_O, TIMEOUT_ERR_O} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: got en=%b alarm=%b rd=%0d err=%b, required all 0",
                     THERMO_EN_O, ALARM_O, RD_DEGREE_O, TIMEOUT_ERR_O);
        end
        RST_I = 1'b0;
        model_clear();
        read_all(rb);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rb[k] !== 7'd0) begin
                errors++;
                $display("FAIL reset_readback ch%0d: got %0d required 0", k, rb[k]);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] rb[8];
        int en0[8], d0;
        int want[NUM_CH] = '{0, 50, 100, 79};
        ana = '{10'd0, 10'd512, 10'd1023, 10'd818};
        ALARM_THRESH_I = 7'd80;
        en0 = en_ch;
        d0  = done_cnt;
        run_scan("scan", -1);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (en_ch[c] - en0[c] !== 1) begin
                errors++;
                $display("FAIL scan_en_pulses ch%0d: got %0d required 1", c, en_ch[c] - en0[c]);
            end
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL scan_done_count: got %0d required 1", done_cnt - d0);
        end
        read_all(rb);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (int'(rb[k]) !== ((k < NUM_CH) ? want[k] : 0) || int'(rb[k]) !== ((k < NUM_CH) ? exp_deg[k] : 0)) begin
                errors++;
                $display("FAIL scan_readback ch%0d: got %0d required %0d", k, rb[k], (k < NUM_CH) ? want[k] : 0);
            end
        end
        checks++;
        if (ALARM_O !== 4'b0100 || ALARM_O !== exp_alarm) begin
            errors++;
            $display("FAIL scan_alarm_thr80: got %b required 0100", ALARM_O);
        end
        ALARM_THRESH_I = 7'd0;
        run_scan("scan_thr0", -1);
        checks++;
        if (ALARM_O !== 4'b1111) begin
            errors++;
            $display("FAIL scan_alarm_thr0: got %b required 1111", ALARM_O);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] rb[8];
        int en0[8], seen, gap, k;
        for (int c = 0; c < NUM_CH; c++) ana[c] = 10'($urandom_range(1023, 0));
        ALARM_THRESH_I = 7'($urandom_range(100, 0));
        apply_analog();
        en0 = en_ch;
        seen = 0;
        gap = -1;
        k = 0;
        START_I = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK_I);
            if (SCAN_DONE_O) begin
                seen++;
                k = 0;
                if (seen == 2) break;
            end else if (seen == 1 && gap < 0) begin
                k++;
                if (THERMO_EN_O) gap = k;
            end
        end
        START_I = 1'b0;
        model_scan(-1);
        model_scan(-1);
        repeat (SCAN_PERIOD + 5) @(negedge CLK_I);
        checks++;
        if (seen != 2 || gap != SCAN_PERIOD + 1) begin
            errors++;
            $display("FAIL b2b_gap: got scans=%0d gap=%0d required scans=2 gap=%0d", seen, gap, SCAN_PERIOD + 1);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (en_ch[c] - en0[c] !== 2) begin
                errors++;
                $display("FAIL b2b_en_pulses ch%0d: got %0d required 2", c, en_ch[c] - en0[c]);
            end
        end
        read_all(rb);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (int'(rb[c]) !== exp_deg[c]) begin
                errors++;
                $display("FAIL b2b_readback ch%0d: got %0d required %0d", c, rb[c], exp_deg[c]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] rb[8];
        for (int it = 0; it < 5; it++) begin
            for (int c = 0; c < NUM_CH; c++) ana[c] = 10'($urandom_range(1023, 0));
            ALARM_THRESH_I = 7'($urandom_range(127, 0));
            run_scan("random", -1);
            read_all(rb);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (int'(rb[k]) !== ((k < NUM_CH) ? exp_deg[k] : 0)) begin
                    errors++;
                    $display("FAIL random%0d_readback ch%0d: got %0d required %0d",
                             it, k, rb[k], (k < NUM_CH) ? exp_deg[k] : 0);
                end
            end
            checks++;
            if (ALARM_O !== exp_alarm) begin
                errors++;
                $display("FAIL random%0d_alarm thr=%0d: got %b required %b", it, ALARM_THRESH_I, ALARM_O, exp_alarm);
            end
        end
    endtask

    task automatic test_hyst();
        logic [9:0] seq[3] = '{10'd819, 10'd818, 10'd788};
`ifdef THERMO_HYST_EN
        logic [2:0] want = 3'b110;
`else
        logic [2:0] want = 3'b100;
`endif
        ALARM_THRESH_I = 7'd80;
        for (int s = 0; s < 3; s++) begin
            for (int c = 1; c < NUM_CH; c++) ana[c] = 10'($urandom_range(1023, 0));
            ana[0] = seq[s];
            run_scan("hyst", -1);
            checks++;
            if (ALARM_O[0] !== want[2-s] || ALARM_O !== exp_alarm) begin
                errors++;
                $display("FAIL hyst_step%0d: got alarm=%b required bit0=%b all=%b", s, ALARM_O, want[2-s], exp_alarm);
            end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] rb[8];
        int en0[8], d0;
        bit ok;
        for (int c = 0; c < NUM_CH; c++) ana[c] = 10'($urandom_range(1023, 0));
        run_scan("timeout_prep", -1);
        ana[1] = ana[1] ^ 10'h200;
        ana[2] = ana[2] ^ 10'h200;
        apply_analog();
        en0 = en_ch;
        d0  = done_cnt;
        drop_ch = 1;
        START_I = 1'b1;
        wait_en_ch(1, ok);
        START_I = 1'b0;
        repeat (TIMEOUT - 1) @(negedge CLK_I);
        checks++;
        if (TIMEOUT_ERR_O !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got err=%b at TIMEOUT-1 cycles after TRIG, required 0", TIMEOUT_ERR_O);
        end
        repeat (2) @(negedge CLK_I);
        checks++;
        if (TIMEOUT_ERR_O !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: got err=%b at TIMEOUT+1 cycles after TRIG, required 1", TIMEOUT_ERR_O);
        end
        for (int i = 0; i < 500 && done_cnt == d0; i++) @(negedge CLK_I);
        model_scan(1);
        repeat (SCAN_PERIOD + 5) @(negedge CLK_I);
        drop_ch = -1;
        checks++;
        if (done_cnt - d0 !== 1 || en_ch[2] - en0[2] !== 1 || en_ch[3] - en0[3] !== 1) begin
            errors++;
            $display("FAIL timeout_continue: got done=%0d en2=%0d en3=%0d required 1 1 1",
                     done_cnt - d0, en_ch[2] - en0[2], en_ch[3] - en0[3]);
        end
        read_all(rb);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (int'(rb[c]) !== exp_deg[c]) begin
                errors++;
                $display("FAIL timeout_readback ch%0d: got %0d required %0d", c, rb[c], exp_deg[c]);
            end
        end
    endtask

    task automatic test_start_drop();
        logic [6:0] rb[8];
        int en0[8], d0, e0;
        bit ok;
        checks++;
        if (TIMEOUT_ERR_O !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b required 1", TIMEOUT_ERR_O);
        end
        for (int c = 0; c < NUM_CH; c++) ana[c] = 10'($urandom_range(1023, 0));
        apply_analog();
        en0 = en_ch;
        d0  = done_cnt;
        START_I = 1'b1;
        wait_en_ch(1, ok);
        START_I = 1'b0;
        for (int i = 0; i < 500 && done_cnt == d0; i++) @(negedge CLK_I);
        model_scan(-1);
        e0 = en_cnt;
        repeat (3 * SCAN_PERIOD) @(negedge CLK_I);
        checks++;
        if (done_cnt - d0 !== 1 || en_cnt !== e0) begin
            errors++;
            $display("FAIL start_drop_stop: got done=%0d extra_en=%0d required 1 0", done_cnt - d0, en_cnt - e0);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (en_ch[c] - en0[c] !== 1) begin
                errors++;
                $display("FAIL start_drop_en ch%0d: got %0d required 1", c, en_ch[c] - en0[c]);
            end
        end
        read_all(rb);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (int'(rb[c]) !== exp_deg[c]) begin
                errors++;
                $display("FAIL start_drop_readback ch%0d: got %0d required %0d", c, rb[c], exp_deg[c]);
            end
        end
        RST_I = 1'b1;
        @(negedge CLK_I);
        RST_I = 1'b0;
        @(negedge CLK_I);
        checks++;
        if (TIMEOUT_ERR_O !== 1'b0 || ALARM_O !== '0) begin
            errors++;
            $display("FAIL err_cleared_by_reset: got err=%b alarm=%b required 0 0", TIMEOUT_ERR_O, ALARM_O);
        end
        checks++;
        if (en_busy !== 0) begin
            errors++;
            $display("FAIL en_while_busy: got %0d pulses required 0", en_busy);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_back_to_back();
        test_random();
        test_hyst();
        test_timeout();
        test_start_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
